tx_sample_player: RTL
=====================

// Module: tx_sample_player
// PURPOSE
//  Transmit-side counterpart of the rx sample store. Host/CPU preloads a
//  waveform of up to DEPTH 16-bit samples into internal block RAM, then a start
//  pulse plays the samples out sequentially to the DAC front-end, one per
//  sample_tick. Sits between the tx control registers and the DAC interface.
// PARAMETERS
//  DATA_W  16   sample width
//  DEPTH   128  RAM entries
//  ADDR_W  7    address width, = clog2(DEPTH)
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rtx_rst_n    in   1       asynchronous reset, active-low
//  wr_en        in   1       RAM write strobe, independent of play state
//  wr_addr      in   ADDR_W  RAM write address
//  wr_data      in   DATA_W  RAM write data
//  len          in   ADDR_W  last sample index (samples played = len+1); sampled at start
//  start        in   1       1-cycle pulse, begins playback from address 0
//  stop         in   1       abort request, level or pulse
//  sample_tick  in   1       DAC-rate strobe, may be high every cycle
//  tx_data      out  DATA_W  current sample to DAC
//  tx_valid     out  1       1-cycle pulse, tx_data updated this cycle
//  busy         out  1       high in PLAY and DRAIN
//  done         out  1       1-cycle pulse on playback end
// BEHAVIOUR
//  - Reset (async, rtx_rst_n=0): state=IDLE, rd_ptr=0, len_q=0, tx_data=0,
//    tx_valid=0, busy=0, done=0. RAM contents NOT cleared (no reset on array).
//  - RAM: simple dual port, sync read, 1-cycle read latency; read-first when
//    wr_addr==rd_ptr in the same cycle (old data returned).
//  - IDLE: start=1 -> len_q<=len, rd_ptr<=0, PLAY. stop ignored. sample_tick ignored.
//  - PLAY: start ignored. On sample_tick: issue read at rd_ptr; next cycle
//    tx_data<=RAM out, tx_valid=1. If rd_ptr==len_q -> DRAIN, else rd_ptr++.
//    stop=1 -> DRAIN this cycle (a tick in the same cycle still issues its read,
//    which completes). stop has priority over the last-sample wrap.
//  - DRAIN: exactly 1 cycle; done=1 (coincides with final tx_valid if a read was
//    issued on the previous cycle); -> IDLE.
//  - start and sample_tick in same cycle in IDLE: first read on next tick, not this one.
//  - len=0: exactly one sample played. len=DEPTH-1: rd_ptr ends at DEPTH-1, no wrap.
//  - tx_data holds last value between pulses and after done.
//  - Reset mid-playback: immediate return to IDLE, no done, no tx_valid.
// CONFIGURATION
//  TX_LOOP_EN defined: at rd_ptr==len_q on tick, rd_ptr<=0 and stay in PLAY
//    (continuous repeat); only stop ends playback (PLAY->DRAIN->IDLE, done pulse).
//  TX_LOOP_EN undefined: single-shot as above; no loop logic synthesised.
// STRUCTURE
//  - Package tx_pkg: state encoding localparams (IDLE=2'd0, PLAY=2'd1,
//    DRAIN=2'd2), default DATA_W/DEPTH/ADDR_W constants.
//  - Sub-module tx_sample_ram: DATA_W x DEPTH simple dual-port sync-read RAM,
//    read-enable driven by PLAY && sample_tick; no reset on read data.
//  - Top: FSM, rd_ptr/len_q counters, output registers.
// TESTING
//  1 Write ram[i]=16'h1000+i for i=0..127; len=3, start, tick every 4 cycles ->
//    tx_valid x4 with 1000,1001,1002,1003; done with 4th tx_valid; busy low after.
//  2 len=0, tick every cycle -> single tx_valid with 16'h1000, done same cycle.
//  3 len=127, tick every cycle -> 128 consecutive tx_valid 1000..107F, no wrap.
//  4 len=10, stop asserted with 3rd tick -> 3 samples (1000..1002), done, IDLE;
//    start during PLAY ignored.
//  5 rtx_rst_n low after 2nd sample -> outputs 0 asynchronously, no done; restart
//    replays from 16'h1000 (RAM kept).
//  6 TX_LOOP_EN: len=1, 6 ticks -> 1000,1001,1000,1001,1000,1001; stop -> done.

Source files
------------

// File: rtl/tx_pkg.sv
// tx_pkg: default geometry and FSM state encoding shared by the tx sample player.
package tx_pkg;
    localparam int TX_DATA_W = 16;
    localparam int TX_DEPTH  = 128;
    localparam int TX_ADDR_W = $clog2(TX_DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
endpackage

// File: rtl/tx_sample_ram.sv
// tx_sample_ram: simple dual-port sync-read waveform RAM, read-first on address collision.
module tx_sample_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/tx_sample_player.sv
// tx_sample_player: plays a preloaded waveform to the DAC, one sample per sample_tick.
// Define TX_LOOP_EN for continuous repeat until stop; default build is single-shot.
module tx_sample_player
    import tx_pkg::*;
#(
    parameter int DATA_W = TX_DATA_W,
    parameter int DEPTH  = TX_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rtx_rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] len,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_tick,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic              done
);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, len_q, len_d;
    logic [DATA_W-1:0] hold_q, ram_q;
    logic              vld_q, rd_en, last;

    assign rd_en = (state_q == PLAY) && sample_tick;
    assign last  = rd_ptr_q == len_q;

    tx_sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_q)
    );

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        if (state_q == IDLE && start) begin
            state_d  = PLAY;
            rd_ptr_d = '0;
            len_d    = len;
        end
        if (rd_en && !last) rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef TX_LOOP_EN
        if (rd_en && last) rd_ptr_d = '0;
        if (state_q == PLAY && stop) state_d = DRAIN;
`else
        if (state_q == PLAY && (stop || (rd_en && last))) state_d = DRAIN;
`endif
        if (state_q == DRAIN) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rtx_rst_n) begin
        if (!rtx_rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            len_q    <= '0;
            vld_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            vld_q    <= rd_en;
            hold_q   <= tx_data;
        end
    end

    // RAM output is unreset, so it is only exposed in the cycle its read lands
    assign tx_data  = vld_q ? ram_q : hold_q;
    assign tx_valid = vld_q;
    assign busy     = (state_q == PLAY) || (state_q == DRAIN);
    assign done     = state_q == DRAIN;
endmodule
